// File: rtl/pe_operand_feeder_if.sv
// Host and PE-side signal bundle for the operand feeder.
// The feeder connects through the slave modport; the host/PE side uses master.
interface pe_operand_feeder_if;
  logic               wr_en;
  logic               wr_sel;
  logic [3:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               go;
  logic [7:0]         len;
  logic               abort;
  logic               busy;
  logic               done;
  logic signed [15:0] result;
  logic               result_sat;
  logic               pe_start;
  logic               pe_awe;
  logic               pe_bwe;
  logic signed [15:0] pe_a;
  logic signed [15:0] pe_b;
  logic [7:0]         pe_max_cntr;
  logic               pe_aff;
  logic               pe_bff;
  logic               pe_se;
  logic signed [15:0] pe_s_out;
  logic               pe_sat;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, go, len, abort,
    input  pe_aff, pe_bff, pe_se, pe_s_out, pe_sat,
    output busy, done, result, result_sat,
    output pe_start, pe_awe, pe_bwe, pe_a, pe_b, pe_max_cntr
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, go, len, abort,
    output pe_aff, pe_bff, pe_se, pe_s_out, pe_sat,
    input  busy, done, result, result_sat,
    input  pe_start, pe_awe, pe_bwe, pe_a, pe_b, pe_max_cntr
  );
endinterface

// File: rtl/pe_operand_feeder.sv
// Streams up to 16 A/B operand pairs from host-loaded buffers into a PE,
// honouring per-stream full flags, then captures the PE result.
//
// state | meaning
// IDLE  | waiting for go; host may load the operand buffers
// START | one-cycle pe_start pulse, pe_max_cntr already valid
// FEED  | A and B streams advance independently, gated by pe_aff/pe_bff
// WAIT  | all pairs sent, waiting for pe_se to capture the result
// DONE  | one-cycle done pulse
module pe_operand_feeder (
  input  logic              clk,
  input  logic              rst_n,
  pe_operand_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, FEED, WAIT, DONE} state_t;

  state_t             state;
  logic signed [15:0] buf_a [16];
  logic signed [15:0] buf_b [16];
  logic [4:0]         eff_len;
  logic [4:0]         eff_len_next;
  logic [4:0]         a_idx;
  logic [4:0]         b_idx;
  logic               a_more;
  logic               b_more;
  logic               a_push;
  logic               b_push;
  logic               busy_q;
  logic               done_q;
  logic               start_q;
  logic signed [15:0] result_q;
  logic               sat_q;

  assign eff_len_next = (bus.len > 8'd16) ? 5'd16 : bus.len[4:0];

  assign a_more = (a_idx < eff_len);
  assign b_more = (b_idx < eff_len);
  // Full flags gate the strobes in the same cycle so no element is lost.
  assign a_push = (state == FEED) && a_more && !bus.pe_aff;
  assign b_push = (state == FEED) && b_more && !bus.pe_bff;

  assign bus.pe_awe      = a_push;
  assign bus.pe_bwe      = b_push;
  assign bus.pe_a        = buf_a[a_idx[3:0]];
  assign bus.pe_b        = buf_b[b_idx[3:0]];
  assign bus.pe_max_cntr = {3'b000, eff_len};
  assign bus.pe_start    = start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.result_sat  = sat_q;

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      if (bus.wr_sel) buf_b[bus.wr_addr] <= bus.wr_data;
      else            buf_a[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      a_idx    <= 5'd0;
      b_idx    <= 5'd0;
      eff_len  <= 5'd0;
      result_q <= 16'sd0;
      sat_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      start_q <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        a_idx  <= 5'd0;
        b_idx  <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.go) begin
              eff_len <= eff_len_next;
              a_idx   <= 5'd0;
              b_idx   <= 5'd0;
              busy_q  <= 1'b1;
              if (bus.len == 8'd0) begin
                state    <= DONE;
                done_q   <= 1'b1;
                result_q <= 16'sd0;
                sat_q    <= 1'b0;
              end else begin
                state   <= START;
                start_q <= 1'b1;
              end
            end
          end
          START: state <= FEED;
          FEED: begin
            if (a_push) a_idx <= a_idx + 5'd1;
            if (b_push) b_idx <= b_idx + 5'd1;
            if (!a_more && !b_more) state <= WAIT;
          end
          WAIT: begin
            if (bus.pe_se) begin
              result_q <= bus.pe_s_out;
              sat_q    <= bus.pe_sat;
              state    <= DONE;
              done_q   <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder: a run-level model (operand queues and
// run phase) checked every cycle, plus hand-computed expectations per scenario.
module tb_pe_operand_feeder;

  logic clk;
  logic rst_n;
  pe_operand_feeder_if bus ();

  pe_operand_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // run-level model: 0 idle, 1 start, 2 feed, 3 wait, 4 done
  int                 m_phase = 0;
  int                 m_eff   = 0;
  logic signed [15:0] m_res   = 16'sd0;
  logic               m_sat   = 1'b0;
  logic signed [15:0] m_a [16];
  logic signed [15:0] m_b [16];
  logic signed [15:0] qa[$];
  logic signed [15:0] qb[$];

  // observation logs for the hand-computed checks
  logic signed [15:0] a_log[$];
  logic signed [15:0] b_log[$];
  int a_cyc[$];
  int b_cyc[$];
  int n_start, n_done, start_cyc, done_cyc, go_cyc, mc_at_start;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string nm, input logic signed [15:0] got[$],
                       input logic signed [15:0] exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  always @(negedge clk) begin
    logic e_awe, e_bwe, feed_done;
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_eff = 0; m_res = 16'sd0; m_sat = 1'b0;
      qa.delete(); qb.delete();
    end
    e_awe = (m_phase == 2) && (qa.size() > 0) && !bus.pe_aff;
    e_bwe = (m_phase == 2) && (qb.size() > 0) && !bus.pe_bff;
    chk("busy",        bus.busy,        m_phase != 0);
    chk("done",        bus.done,        m_phase == 4);
    chk("pe_start",    bus.pe_start,    m_phase == 1);
    chk("pe_awe",      bus.pe_awe,      e_awe);
    chk("pe_bwe",      bus.pe_bwe,      e_bwe);
    chk("pe_max_cntr", bus.pe_max_cntr, m_eff);
    chk("result",      bus.result,      m_res);
    chk("result_sat",  bus.result_sat,  m_sat);
    if (e_awe && bus.pe_awe) chk("pe_a", bus.pe_a, qa[0]);
    if (e_bwe && bus.pe_bwe) chk("pe_b", bus.pe_b, qb[0]);

    if (bus.pe_awe) begin a_log.push_back(bus.pe_a); a_cyc.push_back(cyc); end
    if (bus.pe_bwe) begin b_log.push_back(bus.pe_b); b_cyc.push_back(cyc); end
    if (bus.pe_start) begin n_start++; start_cyc = cyc; mc_at_start = int'(bus.pe_max_cntr); end
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.go && !bus.busy) go_cyc = cyc;

    if (rst_n) begin
      feed_done = (qa.size() == 0) && (qb.size() == 0);
      if (e_awe) void'(qa.pop_front());
      if (e_bwe) void'(qb.pop_front());
      if (m_phase != 0 && bus.abort) begin
        m_phase = 0; qa.delete(); qb.delete();
      end else begin
        case (m_phase)
          0: begin
            if (bus.wr_en) begin
              if (bus.wr_sel) m_b[bus.wr_addr] = bus.wr_data;
              else            m_a[bus.wr_addr] = bus.wr_data;
            end
            if (bus.go) begin
              m_eff = (bus.len > 16) ? 16 : int'(bus.len);
              if (m_eff == 0) begin
                m_phase = 4; m_res = 16'sd0; m_sat = 1'b0;
              end else begin
                m_phase = 1;
                for (int i = 0; i < m_eff; i++) begin
                  qa.push_back(m_a[i]); qb.push_back(m_b[i]);
                end
              end
            end
          end
          1: m_phase = 2;
          2: if (feed_done) m_phase = 3;
          3: if (bus.pe_se) begin
               m_res = bus.pe_s_out; m_sat = bus.pe_sat; m_phase = 4;
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = 4'(addr); bus.wr_data = 16'(data);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic load_std();
    wr(0, 0, 100); wr(0, 1, 200); wr(0, 2, 255); wr(0, 3, 100);
    wr(1, 0, 200); wr(1, 1, 130); wr(1, 2, 256); wr(1, 3, 300);
  endtask

  task automatic clear_logs();
    a_log.delete(); b_log.delete(); a_cyc.delete(); b_cyc.delete();
    n_start = 0; n_done = 0; start_cyc = -1; done_cyc = -1; go_cyc = -1; mc_at_start = -1;
  endtask

  task automatic start_run(input int n);
    clear_logs();
    bus.go = 1'b1; bus.len = 8'(n);
    tick();
    bus.go = 1'b0;
  endtask

  task automatic wait_phase(input int p, input int budget, input string nm);
    int k = 0;
    while (m_phase != p && k < budget) begin tick(); k++; end
    checks++;
    if (m_phase != p) begin
      errors++;
      $display("FAIL %s timeout: phase %0d required %0d", nm, m_phase, p);
    end
  endtask

  task automatic finish_pe(input int s, input logic sat, input string nm);
    wait_phase(3, 60, {nm, "_wait"});
    bus.pe_se = 1'b1; bus.pe_s_out = 16'(s); bus.pe_sat = sat;
    tick();
    bus.pe_se = 1'b0;
    wait_phase(0, 10, {nm, "_idle"});
  endtask

  logic signed [15:0] ea[$];
  logic signed [15:0] eb[$];

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.go = 0; bus.len = 0; bus.abort = 0;
    bus.pe_aff = 0; bus.pe_bff = 0; bus.pe_se = 0; bus.pe_s_out = 0; bus.pe_sat = 0;
    clear_logs();
    tick(); tick();
    chk("reset_busy",   bus.busy, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_mc",     bus.pe_max_cntr, 0);
    rst_n = 1'b1;
    tick();

    // basic run, saturated result
    load_std();
    start_run(4);
    finish_pe(32767, 1'b1, "t1");
    ea = '{16'sd100, 16'sd200, 16'sd255, 16'sd100};
    eb = '{16'sd200, 16'sd130, 16'sd256, 16'sd300};
    chk_q("t1_a", a_log, ea);
    chk_q("t1_b", b_log, eb);
    chk("t1_mc", mc_at_start, 4);
    chk("t1_start_lat", start_cyc - go_cyc, 1);
    chk("t1_a_consec", a_cyc[3] - a_cyc[0], 3);
    chk("t1_result", bus.result, 32767);
    chk("t1_sat", bus.result_sat, 1);
    chk("t1_ndone", n_done, 1);

    // A-side backpressure for 3 cycles after the second A write
    start_run(4);
    begin
      int k = 0;
      while (a_log.size() < 2 && k < 20) begin tick(); k++; end
    end
    bus.pe_aff = 1'b1;
    tick(); tick(); tick();
    bus.pe_aff = 1'b0;
    finish_pe(-5, 1'b0, "t2");
    chk_q("t2_a", a_log, ea);
    chk_q("t2_b", b_log, eb);
    chk("t2_a_gap", a_cyc[2] - a_cyc[1], 4);
    chk("t2_b_consec", b_cyc[3] - b_cyc[0], 3);
    chk("t2_result", bus.result, -5);

    // len = 0 completes immediately with a zero result
    start_run(0);
    wait_phase(0, 10, "t3");
    chk("t3_done_lat", done_cyc - go_cyc, 1);
    chk("t3_nstart", n_start, 0);
    chk("t3_nawe", a_log.size(), 0);
    chk("t3_nbwe", b_log.size(), 0);
    chk("t3_result", bus.result, 0);

    // len = 20 clamps to 16 pairs
    for (int i = 0; i < 16; i++) begin
      wr(0, i, i * 37 - 300);
      wr(1, i, 500 - i * 11);
    end
    start_run(20);
    finish_pe(1234, 1'b0, "t4");
    chk("t4_mc", mc_at_start, 16);
    chk("t4_nawe", a_log.size(), 16);
    chk("t4_nbwe", b_log.size(), 16);
    chk("t4_a15", a_log[15], 16'(15 * 37 - 300));
    chk("t4_b15", b_log[15], 16'(500 - 15 * 11));
    chk("t4_result", bus.result, 1234);

    // go and buffer writes while busy are dropped; abort mid-feed
    load_std();
    start_run(4);
    bus.go = 1'b1; bus.len = 8'd1;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 16'sd7777;
    tick();
    bus.go = 1'b0; bus.wr_en = 1'b0;
    begin
      int k = 0;
      while ((a_log.size() < 2 || b_log.size() < 2) && k < 20) begin tick(); k++; end
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_busy", bus.busy, 0);
    tick(); tick();
    chk("t5_ndone", n_done, 0);
    chk("t5_nstart", n_start, 1);
    chk("t5_result", bus.result, 1234);
    start_run(4);
    finish_pe(-300, 1'b0, "t5b");
    chk_q("t5b_a", a_log, ea);
    chk("t5b_result", bus.result, -300);

    // reset while waiting for the PE result
    start_run(3);
    wait_phase(3, 60, "t6_wait");
    rst_n = 1'b0;
    #1;
    chk("t6_busy",     bus.busy, 0);
    chk("t6_done",     bus.done, 0);
    chk("t6_start",    bus.pe_start, 0);
    chk("t6_awe",      bus.pe_awe, 0);
    chk("t6_bwe",      bus.pe_bwe, 0);
    chk("t6_mc",       bus.pe_max_cntr, 0);
    chk("t6_result",   bus.result, 0);
    chk("t6_sat",      bus.result_sat, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_ndone", n_done, 0);
    start_run(2);
    finish_pe(555, 1'b1, "t6b");
    ea = '{16'sd100, 16'sd200};
    chk_q("t6b_a", a_log, ea);
    chk("t6b_ndone", n_done, 1);
    chk("t6b_result", bus.result, 555);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_operand_feeder.md
PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port wr_en, input, 1, host operand-buffer write strobe.
REQ-004 SHALL have port wr_sel, input, 1, buffer select (0 = A, 1 = B).
REQ-005 SHALL have port wr_addr, input, 4, buffer entry index 0..15.
REQ-006 SHALL have port wr_data, input, 16, signed operand.
REQ-007 SHALL have port go, input, 1, single-cycle run request.
REQ-008 SHALL have port len, input, 8, number of A/B pairs to stream.
REQ-009 SHALL have port abort, input, 1, synchronous run cancel.
REQ-010 SHALL have outputs busy (1), done (1, one-cycle pulse), result (16, signed), result_sat (1).
REQ-011 SHALL have PE-side outputs pe_start (1), pe_awe (1), pe_bwe (1), pe_a (16, signed), pe_b (16, signed), pe_max_cntr (8).
REQ-012 SHALL have PE-side inputs pe_aff (1), pe_bff (1), pe_se (1), pe_s_out (16, signed), pe_sat (1).

Function
REQ-013 SHALL hold two 16x16 signed buffers A and B; a write occurs when wr_en=1 and busy=0; writes while busy=1 are dropped.
REQ-014 SHALL implement states IDLE, START, FEED, WAIT, DONE; busy=1 in every state except IDLE.
REQ-015 SHALL, in IDLE on go=1, latch eff_len = min(len,16) and move to START; if len=0, move directly to DONE with result=0, result_sat=0, no pe_start.
REQ-016 SHALL drive pe_max_cntr = latched eff_len, stable for the whole run; go while busy=1 ignored.
REQ-017 SHALL assert pe_start for exactly one cycle in START, then enter FEED with a_idx=b_idx=0.
REQ-018 SHALL in FEED drive pe_awe = (a_idx<eff_len) and not pe_aff, same cycle (combinational gating); pe_a = A[a_idx]; a_idx increments each cycle pe_awe=1.
REQ-019 SHALL treat the B stream identically and independently (pe_bwe, pe_bff, b_idx, B[]); A and B may be written in the same cycle.
REQ-020 SHALL never skip or duplicate an element under backpressure; a full flag only delays.
REQ-021 SHALL move FEED->WAIT the cycle after both a_idx and b_idx reach eff_len; pe_awe/pe_bwe=0 outside FEED.
REQ-022 SHALL in WAIT, on pe_se=1, capture result=pe_s_out and result_sat=pe_sat, and move to DONE.
REQ-023 SHALL assert done for exactly one cycle in DONE, then return to IDLE; result/result_sat hold until next capture.
REQ-024 SHALL on abort=1 in any non-IDLE state return to IDLE next cycle with no done pulse, result unchanged, all PE strobes 0; abort has priority over pe_se in the same cycle.
REQ-025 SHALL ignore pe_se outside WAIT.

Reset
REQ-026 SHALL on rst_n=0 immediately force IDLE, busy=0, done=0, pe_start=0, pe_awe=0, pe_bwe=0, a_idx=b_idx=0, pe_max_cntr=0, result=0, result_sat=0; buffer contents are not reset.
REQ-027 SHALL on reset mid-run abandon the run with no done pulse; first go after release starts a clean run.

Verification
REQ-028 Load A={100,200,255,100}, B={200,130,256,300}, len=4, flags low -> pe_max_cntr=4, pe_start one cycle after go, 4 awe and 4 bwe on consecutive cycles with data in order; model pe_se with s_out=32767, sat=1 -> result=32767, result_sat=1, one done pulse.
REQ-029 Same load, pe_aff high 3 cycles after second A write -> A stream pauses 3 cycles, resumes at A[2]=255, total 4 A writes, B stream unaffected.
REQ-030 len=0 -> done pulse one cycle after go, result=0, no pe_start/awe/bwe; len=20 -> pe_max_cntr=16, 16 pairs streamed.
REQ-031 abort during FEED after 2 pairs -> IDLE next cycle, no done, result keeps prior value; go while busy and wr_en while busy -> no effect on run or buffers.
REQ-032 rst_n low during WAIT -> all outputs at REQ-026 values without clock edge; subsequent run with len=2 completes normally.
